// File: rtl/complex_mac_stream.sv
// Streaming complex dot-product engine: accumulates N products of x*y or x*conj(y)
// through a one-stage registered multiplier, then holds the result until it is accepted.
module complex_mac_stream #(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int ACC_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               conj,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*W-1:0]     x_in,
  input  logic [2*W-1:0]     y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_re,
  output logic [ACC_W-1:0]   acc_im,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     conj_q;
  logic                     fire;
  logic                     p_valid;
  logic signed [ACC_W-1:0]  a, b, c, d;
  logic signed [ACC_W-1:0]  ac, bd, ad, bc;
  logic signed [ACC_W-1:0]  prod_re, prod_im;
  logic signed [ACC_W-1:0]  p_re, p_im;
  logic signed [ACC_W-1:0]  sum_re, sum_im;

  assign fire = (state == RUN) && in_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (fire && (beat_cnt == LAST_BEAT)) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted, not just after its edge.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      in_ready  = (state == RUN);
      out_valid = (state == HOLD);
      busy      = (state != IDLE);
      done      = (state == HOLD) && out_ready;
    end
  end

  assign a = ACC_W'($signed(x_in[2*W-1:W]));
  assign b = ACC_W'($signed(x_in[W-1:0]));
  assign c = ACC_W'($signed(y_in[2*W-1:W]));
  assign d = ACC_W'($signed(y_in[W-1:0]));

  assign ac = a * c;
  assign bd = b * d;
  assign ad = a * d;
  assign bc = b * c;

  always_comb begin
    prod_re = ac - bd;
    prod_im = ad + bc;
    if (conj_q) begin
      prod_re = ac + bd;
      prod_im = bc - ad;
    end
  end

  // NOTE: the product registers carry no reset; p_valid alone qualifies them, so their contents after reset never matter.
  always_ff @(posedge clk) begin
    if (fire) begin
      p_re <= prod_re;
      p_im <= prod_im;
    end
  end

  assign sum_re = $signed(acc_re) + p_re;
  assign sum_im = $signed(acc_im) + p_im;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_re   <= '0;
      acc_im   <= '0;
      beat_cnt <= '0;
      p_valid  <= 1'b0;
      conj_q   <= 1'b0;
    end else begin
      p_valid <= fire;
      if ((state == IDLE) && start) begin
        acc_re   <= '0;
        acc_im   <= '0;
        beat_cnt <= '0;
        conj_q   <= conj;
      end else begin
        if (p_valid) begin
          acc_re <= sum_re;
          acc_im <= sum_im;
        end
        if (fire) beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_complex_mac_stream.sv
// Directed bench for complex_mac_stream: hand-computed dot products, stalls, back-pressure,
// mid-run reset and spurious start pulses.
module tb_complex_mac_stream;
  localparam int W     = 4;
  localparam int N     = 4;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst, start, conj, in_valid, out_ready;
  logic [2*W-1:0]   x_in, y_in;
  logic             in_ready, out_valid, busy, done;
  logic [ACC_W-1:0] acc_re, acc_im;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] xs[4];
  logic [7:0] ys[4];
  logic [7:0] xn[4];

  always #5 clk = ~clk;

  complex_mac_stream #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .conj(conj),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_re(acc_re), .acc_im(acc_im), .busy(busy), .done(done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] pk(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {r[3:0], i[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Start a run; conj is flipped right after the start cycle to show it is latched.
  task automatic do_start(input logic c);
    start = 1'b1;
    conj  = c;
    step();
    start = 1'b0;
    conj  = ~c;
  endtask

  task automatic beat(input logic [7:0] x, input logic [7:0] y);
    int t = 0;
    in_valid = 1'b1;
    x_in = x;
    y_in = y;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    chk("beat_accept_timeout", t < 20, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_beats(input string tag, input int gap, input logic stall_start);
    for (int i = 0; i < 4; i++) begin
      beat(xs[i], ys[i]);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          start = stall_start;
          conj  = 1'b1;
          #1;
          chk({tag, "_stall_in_ready"}, in_ready, 1);
          step();
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic collect(input string tag, input int re, input int im,
                         input int hold, input int lat, input logic hold_start);
    int t = 0;
    out_ready = (hold == 0);
    while (!out_valid && t < 20) begin
      chk({tag, "_pre_in_ready"}, in_ready, 0);
      step();
      t++;
    end
    if (lat >= 0) chk({tag, "_latency"}, t, lat);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_out_valid"}, out_valid, 1);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      chk({tag, "_hold_done"}, done, 0);
      chk({tag, "_hold_re"}, $signed(acc_re), re);
      chk({tag, "_hold_im"}, $signed(acc_im), im);
      step();
    end
    out_ready = 1'b1;
    start = hold_start;
    conj  = 1'b1;
    #1;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_re"}, $signed(acc_re), re);
    chk({tag, "_im"}, $signed(acc_im), im);
    step();
    start = 1'b0;
    chk({tag, "_after_done"}, done, 0);
    chk({tag, "_after_busy"}, busy, 0);
    chk({tag, "_after_out_valid"}, out_valid, 0);
    chk({tag, "_idle_re"}, $signed(acc_re), re);
    chk({tag, "_idle_im"}, $signed(acc_im), im);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; conj = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0;
    xs[0] = pk(2, 3); xs[1] = pk(2, 2); xs[2] = pk(1, 0); xs[3] = pk(6, 2);
    ys[0] = pk(2, 1); ys[1] = pk(1, 2); ys[2] = pk(1, 3); ys[3] = pk(4, 5);
    for (int i = 0; i < 4; i++) xn[i] = pk(-8, -8);

    // Reset state.
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", $signed(acc_re), 0);
    chk("rst_im", $signed(acc_im), 0);
    rst = 1'b0;
    step();

    // Back-to-back x*y, immediate acceptance: out_valid two cycles after the last beat.
    do_start(1'b0);
    chk("t1_busy_run", busy, 1);
    run_beats("t1", 0, 1'b0);
    chk("t1_drain_busy", busy, 1);
    collect("t1", 14, 55, 0, 1, 1'b0);

    // Conjugate mode.
    do_start(1'b1);
    run_beats("t2", 0, 1'b0);
    collect("t2", 48, -23, 0, 1, 1'b0);

    // Most-negative operands, no overflow.
    xs = xn;
    ys = xn;
    do_start(1'b0);
    run_beats("t3", 0, 1'b0);
    collect("t3", 0, 512, 0, 1, 1'b0);

    // Stalled input and back-pressured output.
    xs[0] = pk(2, 3); xs[1] = pk(2, 2); xs[2] = pk(1, 0); xs[3] = pk(6, 2);
    ys[0] = pk(2, 1); ys[1] = pk(1, 2); ys[2] = pk(1, 3); ys[3] = pk(4, 5);
    do_start(1'b0);
    run_beats("t4", 2, 1'b0);
    collect("t4", 14, 55, 5, 1, 1'b0);

    // Reset after the second beat discards the run.
    do_start(1'b1);
    beat(xs[0], ys[0]);
    beat(xs[1], ys[1]);
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_done", done, 0);
    step();
    chk("t5_rst_re", $signed(acc_re), 0);
    chk("t5_rst_im", $signed(acc_im), 0);
    chk("t5_rst_busy_edge", busy, 0);
    step();
    rst = 1'b0;
    step();
    do_start(1'b0);
    run_beats("t5", 0, 1'b0);
    collect("t5", 14, 55, 0, 1, 1'b0);

    // Spurious start pulses in RUN stalls and in the accepting HOLD cycle.
    do_start(1'b0);
    run_beats("t6", 1, 1'b1);
    collect("t6", 14, 55, 2, 1, 1'b1);
    step();
    chk("t6_still_idle_busy", busy, 0);
    chk("t6_still_idle_in_ready", in_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_mac_stream.md
COMPLEX_MAC_STREAM -- requirements
Module: complex_mac_stream

Interface
REQ-001 Parameter W, default 4: bit width of each signed real/imag component of an operand.
REQ-002 Parameter N, default 4: number of complex element pairs per dot product; N >= 1.
REQ-003 Parameter ACC_W, default 12: width of each signed accumulator component; ACC_W >= 2*W + 1 + clog2(N), so overflow cannot occur.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a new dot product; sampled only in IDLE.
REQ-007 conj  input  1  sampled with start; 1 = accumulate x*conj(y), 0 = x*y.
REQ-008 in_valid  input  1  x_in/y_in beat valid.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 x_in  input  2*W  operand x packed {re[2W-1:W], im[W-1:0]}, two's complement.
REQ-011 y_in  input  2*W  operand y, same packing as x_in.
REQ-012 out_valid  output  1  result on acc_re/acc_im is valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 acc_re  output  ACC_W  signed real part of the dot product.
REQ-015 acc_im  output  ACC_W  signed imaginary part of the dot product.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  high only in the cycle where out_valid && out_ready.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, HOLD.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 -> clear both accumulators and the beat counter, latch conj, go to RUN.
REQ-020 RUN: in_ready=1; each cycle with in_valid && in_ready is one beat and increments the beat counter; in_valid=0 cycles are stalls with no state change.
REQ-021 On the Nth beat, RUN -> DRAIN; in_ready is 0 from the DRAIN cycle onward.
REQ-022 Multiply is one registered pipeline stage: products of the beat in cycle k are added to the accumulators at the end of cycle k+1.
REQ-023 For x=(a,b) and y=(c,d): conj=0 adds (a*c - b*d, a*d + b*c); conj=1 adds (a*c + b*d, b*c - a*d); all operands are sign-extended to ACC_W.
REQ-024 DRAIN lasts exactly one cycle, absorbs the last product, then goes to HOLD.
REQ-025 HOLD: out_valid=1, acc_re/acc_im held stable; out_ready=1 -> done=1 that cycle, next state IDLE.
REQ-026 acc_re/acc_im keep their last value in IDLE until the next start clears them.
REQ-027 start is ignored in RUN, DRAIN and HOLD; conj changes after the start cycle have no effect on the current run.
REQ-028 Latency with back-to-back beats: start in cycle 0 -> beats in cycles 1..N -> DRAIN in cycle N+1 -> out_valid first high in cycle N+2.
REQ-029 start together with out_ready in the HOLD cycle: the result is consumed and start is ignored; a new start must come in IDLE.

Reset
REQ-030 rst=1 at a clock edge forces IDLE; acc_re=0, acc_im=0, beat counter=0, pipeline valid=0, latched conj=0.
REQ-031 While in reset, in_ready=0, out_valid=0, busy=0, done=0.
REQ-032 Reset in any state, including mid-RUN or HOLD, discards the partial or pending result; the first start after reset runs normally.

Verification
REQ-033 N=4, W=4, conj=0, x=(2,3),(2,2),(1,0),(6,2), y=(2,1),(1,2),(1,3),(4,5), back-to-back, out_ready=1 -> out_valid in cycle 6, result (14,55), done one cycle.
REQ-034 Same operands, conj=1 -> result (48,-23).
REQ-035 All x=y=(-8,-8), conj=0 -> result (0,512), no overflow.
REQ-036 in_valid toggling 1,0,0,1,... and out_ready held low 5 cycles in HOLD -> same result as REQ-033; outputs stable and in_ready=0 while held; done only on acceptance.
REQ-037 rst asserted after the 2nd beat, then a new start with the REQ-033 vectors -> all outputs zero during reset, final result (14,55).
REQ-038 start pulsed during RUN and HOLD -> ignored; beat count and result unchanged.
